// File: rtl/l1_write_buffer_pkg.sv
// l1_write_buffer_pkg
//   Shared definitions for the L1 line write buffer: default bus widths,
//   downstream (memory-side) state encoding and the per-entry status record.
package l1_write_buffer_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned LINE_W_DEF = 128;

  // Memory-side transaction state.
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_WR   = 2'd1,
    DS_RD   = 2'd2
  } ds_state_e;

  // Status half of an entry. Address and line data are kept in separately
  // sized arrays so that ADDR_W/LINE_W remain overridable per instance.
  typedef struct packed {
    logic valid;
    logic inflight;
  } wb_entry_t;

endpackage

// File: rtl/l1_write_buffer_if.sv
// l1_write_buffer_if
//   Line-granular request/ready bus. The master issues read/write with
//   addr/wdata and holds the request until a one-cycle ready pulse; the slave
//   returns rdata alongside ready for reads.
//   master: drives read, write, addr, wdata; receives rdata, ready
//   slave : receives read, write, addr, wdata; drives rdata, ready
interface l1_write_buffer_if
  import l1_write_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);

endinterface

// File: rtl/l1_write_buffer_wb_entry_array.sv
// wb_entry_array
//   FIFO-ordered entry storage for the write buffer.
//   clk, rst_n        : clock, asynchronous active-low reset (clears entries)
//   push/push_*       : append a new line at the tail
//   coal_en/coal_data : overwrite the data of the non-inflight matching entry
//   mark_inflight     : flag the head entry as being written to memory
//   pop               : retire the head entry
//   lk_addr           : lookup address for the parallel compare
//   hit_any/hit_data  : any valid match, data of the newest match
//   nim_hit/nim_ptr   : a valid non-inflight match and its slot
//   head_ptr/addr/data: head slot and its contents
//   count, full       : occupancy
module wb_entry_array
  import l1_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [LINE_W-1:0] push_data,
  input  logic              coal_en,
  input  logic [LINE_W-1:0] coal_data,
  input  logic              mark_inflight,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              hit_any,
  output logic [LINE_W-1:0] hit_data,
  output logic              nim_hit,
  output logic [PTR_W-1:0]  nim_ptr,
  output logic [PTR_W-1:0]  head_ptr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [LINE_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  wb_entry_t         ent_q  [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  // Walk from head toward tail so the last match seen is the newest one.
  // At most one valid entry is non-inflight per address, because writes to
  // such an address always coalesce.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    hit_any  = 1'b0;
    hit_data = '0;
    nim_hit  = 1'b0;
    nim_ptr  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (ent_q[idx].valid && addr_q[idx] == lk_addr) begin
        hit_any  = 1'b1;
        hit_data = data_q[idx];
        if (!ent_q[idx].inflight) begin
          nim_hit = 1'b1;
          nim_ptr = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_q[tail_q] <= '{valid: 1'b1, inflight: 1'b0};
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (mark_inflight) begin
        ent_q[head_q].inflight <= 1'b1;
      end
      if (pop) begin
        ent_q[head_q] <= '0;
        head_q        <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset: it is only observed through valid flags.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
    if (coal_en) begin
      data_q[nim_ptr] <= coal_data;
    end
  end

  assign head_ptr  = head_q;
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/l1_write_buffer.sv
// l1_write_buffer
//   Line write buffer between the L1 data cache memory port and external
//   memory. Absorbs writebacks, coalesces same-address writes, serves refill
//   reads from buffered lines, and forwards read misses ahead of draining.
//   clk          : clock
//   proc_reset_n : asynchronous active-low reset; discards buffered lines
//   cache        : slave side of the cache request bus
//   mem          : master side of the external memory bus
//   wb_empty     : no buffered lines and nothing outstanding downstream
module l1_write_buffer
  import l1_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic               clk,
  input  logic               proc_reset_n,
  l1_write_buffer_if.slave   cache,
  l1_write_buffer_if.master  mem,
  output logic               wb_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ds_state_e         state_q, state_d;
  logic              miss_pend_q, miss_pend_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              cache_ready_q, cache_ready_d;
  logic [LINE_W-1:0] cache_rdata_q, cache_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_empty_q, wb_empty_d;

  logic              push, coal, mark, pop;
  logic              hit_any, nim_hit, full;
  logic [LINE_W-1:0] hit_data, head_data;
  logic [ADDR_W-1:0] head_addr;
  logic [PTR_W-1:0]  nim_ptr, head_ptr;
  logic [CNT_W-1:0]  count, count_nx;
  logic              cache_idle;

  wb_entry_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_entries (
    .clk          (clk),
    .rst_n        (proc_reset_n),
    .push         (push),
    .push_addr    (cache.addr),
    .push_data    (cache.wdata),
    .coal_en      (coal),
    .coal_data    (cache.wdata),
    .mark_inflight(mark),
    .pop          (pop),
    .lk_addr      (cache.addr),
    .hit_any      (hit_any),
    .hit_data     (hit_data),
    .nim_hit      (nim_hit),
    .nim_ptr      (nim_ptr),
    .head_ptr     (head_ptr),
    .head_addr    (head_addr),
    .head_data    (head_data),
    .count        (count),
    .full         (full)
  );

  // The cache holds its request until ready, so skip the ready cycle and any
  // cycle in which its read miss is still being serviced.
  assign cache_idle = !cache_ready_q && !miss_pend_q && (state_q != DS_RD);

  always_comb begin
    state_d       = state_q;
    miss_pend_d   = miss_pend_q;
    miss_addr_d   = miss_addr_q;
    cache_ready_d = 1'b0;
    cache_rdata_d = cache_rdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    push          = 1'b0;
    coal          = 1'b0;
    mark          = 1'b0;
    pop           = 1'b0;

    // Cache side; a simultaneous read+write is handled as a write.
    if (cache_idle && cache.write) begin
      if (nim_hit) begin
        coal          = 1'b1;
        cache_ready_d = 1'b1;
      end else if (!full) begin
        push          = 1'b1;
        cache_ready_d = 1'b1;
      end
    end else if (cache_idle && cache.read) begin
      if (hit_any) begin
        cache_ready_d = 1'b1;
        cache_rdata_d = hit_data;
      end else begin
        miss_pend_d = 1'b1;
        miss_addr_d = cache.addr;
      end
    end

    // Memory side.
    case (state_q)
      DS_IDLE: begin
        if (miss_pend_q) begin
          state_d     = DS_RD;
          mem_read_d  = 1'b1;
          mem_addr_d  = miss_addr_q;
          miss_pend_d = 1'b0;
        end else if (count != '0) begin
          state_d     = DS_WR;
          mem_write_d = 1'b1;
          mem_addr_d  = head_addr;
          mark        = 1'b1;
          // A coalesce into the head on this same edge must reach memory,
          // otherwise the stale line would be written and the new one lost.
          mem_wdata_d = (coal && nim_ptr == head_ptr) ? cache.wdata : head_data;
        end
      end
      DS_WR: begin
        if (mem.ready) begin
          state_d     = DS_IDLE;
          mem_write_d = 1'b0;
          pop         = 1'b1;
        end
      end
      DS_RD: begin
        if (mem.ready) begin
          state_d       = DS_IDLE;
          mem_read_d    = 1'b0;
          cache_ready_d = 1'b1;
          cache_rdata_d = mem.rdata;
        end
      end
      default: state_d = DS_IDLE;
    endcase

    count_nx   = count + CNT_W'(push) - CNT_W'(pop);
    wb_empty_d = (count_nx == '0) && (state_d == DS_IDLE) && !miss_pend_d;
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q       <= DS_IDLE;
      miss_pend_q   <= 1'b0;
      miss_addr_q   <= '0;
      cache_ready_q <= 1'b0;
      cache_rdata_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_empty_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      miss_pend_q   <= miss_pend_d;
      miss_addr_q   <= miss_addr_d;
      cache_ready_q <= cache_ready_d;
      cache_rdata_q <= cache_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_empty_q    <= wb_empty_d;
    end
  end

  assign cache.ready = cache_ready_q;
  assign cache.rdata = cache_rdata_q;
  assign mem.read    = mem_read_q;
  assign mem.write   = mem_write_q;
  assign mem.addr    = mem_addr_q;
  assign mem.wdata   = mem_wdata_q;
  assign wb_empty    = wb_empty_q;

endmodule

// File: tb/tb_l1_write_buffer.sv
// tb_l1_write_buffer
//   Directed bench for l1_write_buffer (DEPTH=4, 28-bit addresses, 128-bit
//   lines). Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_l1_write_buffer;

  localparam int unsigned AW    = 28;
  localparam int unsigned LW    = 128;
  localparam int unsigned DEPTH = 4;

  localparam logic [LW-1:0] D_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] D_H  = {4{32'h1111_2222}};
  localparam logic [LW-1:0] D_A  = {4{32'hAAAA_0001}};
  localparam logic [LW-1:0] D_X  = {4{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] D_Y  = {4{32'h0BAD_F00D}};
  localparam logic [LW-1:0] D_B  = {4{32'hB0B0_B0B0}};
  localparam logic [LW-1:0] D_E  = {4{32'hEEEE_0040}};
  localparam logic [LW-1:0] D_R  = {4{32'h3030_5A5A}};

  logic clk = 1'b0;
  logic proc_reset_n = 1'b0;
  logic wb_empty;

  l1_write_buffer_if #(.ADDR_W(AW), .LINE_W(LW)) cache_if ();
  l1_write_buffer_if #(.ADDR_W(AW), .LINE_W(LW)) mem_if ();

  l1_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk         (clk),
    .proc_reset_n(proc_reset_n),
    .cache       (cache_if),
    .mem         (mem_if),
    .wb_empty    (wb_empty)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_crdy"},  cache_if.ready, 1'b0);
    chk({tag, "_rdata"}, cache_if.rdata, '0);
    chk({tag, "_mrd"},   mem_if.read,    1'b0);
    chk({tag, "_mwr"},   mem_if.write,   1'b0);
    chk({tag, "_maddr"}, mem_if.addr,    '0);
    chk({tag, "_mwd"},   mem_if.wdata,   '0);
    chk({tag, "_empty"}, wb_empty,       1'b1);
  endtask

  task automatic do_reset(input string tag);
    cache_if.read  = 1'b0;
    cache_if.write = 1'b0;
    mem_if.ready   = 1'b0;
    proc_reset_n   = 1'b0;
    tick();
    check_idle(tag);
    proc_reset_n = 1'b1;
    tick();
  endtask

  // Write accepted with one-cycle latency, then one idle cycle.
  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] d,
                          input bit both);
    cache_if.write = 1'b1;
    cache_if.read  = both;
    cache_if.addr  = a;
    cache_if.wdata = d;
    tick();
    chk({tag, "_ack"}, cache_if.ready, 1'b1);
    cache_if.write = 1'b0;
    cache_if.read  = 1'b0;
    tick();
  endtask

  // Wait for the next memory request, check it, answer two cycles later.
  task automatic mem_serve(input string tag, input bit is_wr, input logic [AW-1:0] a,
                           input logic [LW-1:0] d_wr, input logic [LW-1:0] d_rd);
    int unsigned n = 0;
    while (!(mem_if.write || mem_if.read) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"},  mem_if.write | mem_if.read, 1'b1);
    chk({tag, "_kind"}, mem_if.write, is_wr);
    chk({tag, "_addr"}, mem_if.addr, a);
    if (is_wr) chk({tag, "_wdata"}, mem_if.wdata, d_wr);
    tick();
    tick();
    mem_if.ready = 1'b1;
    mem_if.rdata = d_rd;
    tick();
    mem_if.ready = 1'b0;
    mem_if.rdata = '0;
  endtask

  initial begin
    bit seen;
    cache_if.read  = 1'b0;
    cache_if.write = 1'b0;
    cache_if.addr  = '0;
    cache_if.wdata = '0;
    mem_if.ready   = 1'b0;
    mem_if.rdata   = '0;

    // Power-on reset.
    tick();
    tick();
    check_idle("rst");
    proc_reset_n = 1'b1;
    tick();

    // Single write: ack at T+1, drain visible at T+2, empty after mem_ready.
    cache_if.write = 1'b1;
    cache_if.addr  = 28'h0000010;
    cache_if.wdata = D_A5;
    tick();
    chk("sw_ack", cache_if.ready, 1'b1);
    cache_if.write = 1'b0;
    tick();
    chk("sw_ack_pulse", cache_if.ready, 1'b0);
    chk("sw_mwr", mem_if.write, 1'b1);
    chk("sw_maddr", mem_if.addr, 28'h0000010);
    chk("sw_mwd", mem_if.wdata, D_A5);
    chk("sw_busy", wb_empty, 1'b0);
    tick();
    tick();
    chk("sw_hold", mem_if.write, 1'b1);
    mem_if.ready = 1'b1;
    tick();
    mem_if.ready = 1'b0;
    chk("sw_mwr_drop", mem_if.write, 1'b0);
    chk("sw_empty", wb_empty, 1'b1);

    // Read hit on the inflight line, then reset in the middle of its drain.
    cache_if.write = 1'b1;
    cache_if.addr  = 28'h0000010;
    cache_if.wdata = D_H;
    tick();
    chk("rh_wack", cache_if.ready, 1'b1);
    cache_if.write = 1'b0;
    cache_if.read  = 1'b1;
    tick();
    chk("rh_gap", cache_if.ready, 1'b0);
    tick();
    chk("rh_ack", cache_if.ready, 1'b1);
    chk("rh_data", cache_if.rdata, D_H);
    cache_if.read = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= mem_if.read;
      tick();
    end
    chk("rh_no_mrd", seen, 1'b0);
    chk("rh_draining", mem_if.write, 1'b1);
    do_reset("mid_rst");
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= mem_if.write;
    end
    chk("mid_rst_nowr", seen, 1'b0);
    chk("mid_rst_empty", wb_empty, 1'b1);

    // Full: 0x10 inflight plus three queued; 0x50 must wait for a slot.
    do_write("f10", 28'h10, D_A, 1'b0);
    do_write("f20", 28'h20, D_X, 1'b0);
    do_write("f30", 28'h30, D_Y, 1'b0);
    do_write("f40", 28'h40, D_B, 1'b0);
    cache_if.write = 1'b1;
    cache_if.addr  = 28'h50;
    cache_if.wdata = D_E;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= cache_if.ready;
    end
    chk("full_hold", seen, 1'b0);
    chk("full_inflight", mem_if.addr, 28'h10);
    mem_if.ready = 1'b1;
    tick();
    mem_if.ready = 1'b0;
    chk("full_gap", cache_if.ready, 1'b0);
    tick();
    chk("full_ack", cache_if.ready, 1'b1);
    cache_if.write = 1'b0;
    chk("full_next_wr", mem_if.write, 1'b1);
    chk("full_next_addr", mem_if.addr, 28'h20);
    do_reset("full_rst");

    // Coalesce behind an inflight head; read returns the newer 0x10 line.
    do_write("c10a", 28'h10, D_A, 1'b0);
    do_write("c20x", 28'h20, D_X, 1'b0);
    do_write("c20y", 28'h20, D_Y, 1'b1);
    do_write("c10b", 28'h10, D_B, 1'b0);
    cache_if.read = 1'b1;
    cache_if.addr = 28'h10;
    tick();
    chk("c_rd_ack", cache_if.ready, 1'b1);
    chk("c_rd_newest", cache_if.rdata, D_B);
    cache_if.read = 1'b0;
    tick();
    mem_serve("co0", 1'b1, 28'h10, D_A, '0);
    mem_serve("co1", 1'b1, 28'h20, D_Y, '0);
    mem_serve("co2", 1'b1, 28'h10, D_B, '0);
    chk("co_empty", wb_empty, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= mem_if.write | mem_if.read;
    end
    chk("co_quiet", seen, 1'b0);

    // Read miss is issued before the queued 0x40 drains.
    do_write("p10", 28'h10, D_A, 1'b0);
    do_write("p40", 28'h40, D_E, 1'b0);
    cache_if.read = 1'b1;
    cache_if.addr = 28'h30;
    tick();
    chk("rp_noack", cache_if.ready, 1'b0);
    chk("rp_wr_busy", mem_if.addr, 28'h10);
    mem_serve("rp0", 1'b1, 28'h10, D_A, '0);
    mem_serve("rp1", 1'b0, 28'h30, '0, D_R);
    chk("rp_ack", cache_if.ready, 1'b1);
    chk("rp_data", cache_if.rdata, D_R);
    cache_if.read = 1'b0;
    mem_serve("rp2", 1'b1, 28'h40, D_E, '0);
    chk("rp_empty", wb_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
